// File: rtl/seqsum_sink.sv
// rtl/seqsum_sink.sv - sink FIFO for seqsum words with per-sample delta, over-limit flag and sample counter
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   y/y_vld   input sum word and its valid; y_rdy = FIFO not full
//   lim       unsigned threshold; any accepted y > lim sets the sticky over flag
//   clr       clears over, cnt and the previous-sample history (FIFO untouched)
//   out_data  head-of-FIFO sum value
//   out_dlt   head-of-FIFO delta (y minus previous accepted y, mod 2^32)
//   out_vld   FIFO not empty; out_rdy pops the head
//   over      sticky over-limit flag
//   cnt       saturating count of accepted samples

module seqsum_sink #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      y,
    input  logic             y_vld,
    output logic             y_rdy,
    input  logic [31:0]      lim,
    input  logic             clr,
    output logic [31:0]      out_data,
    output logic [31:0]      out_dlt,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic             over,
    output logic [CNT_W-1:0] cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_OCC = (AW + 1)'(DEPTH);

    logic [31:0]   mem_data [DEPTH];
    logic [31:0]   mem_dlt  [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   occ;
    logic [31:0]   prev;
    logic          first;
    logic          push;
    logic          pop;
    logic [31:0]   delta;

    assign y_rdy    = (occ != FULL_OCC);
    assign out_vld  = (occ != '0);
    assign push     = y_vld && y_rdy;
    assign pop      = out_vld && out_rdy;
    assign out_data = mem_data[rd_ptr];
    assign out_dlt  = mem_dlt[rd_ptr];

    // A clr in the same cycle as a push restarts the history first,
    // so that sample is treated as the first one.
    assign delta = (first || clr) ? y : (y - prev);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= y;
            mem_dlt[wr_ptr]  <= delta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            prev   <= '0;
            first  <= 1'b1;
            over   <= 1'b0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                prev   <= y;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase

            if (push) begin
                first <= 1'b0;
            end else if (clr) begin
                first <= 1'b1;
            end

            // clr then the coincident push: the push result wins over the clear
            if (push && (y > lim)) begin
                over <= 1'b1;
            end else if (clr) begin
                over <= 1'b0;
            end

            if (clr) begin
                cnt <= CNT_W'(push);
            end else if (push && (cnt != {CNT_W{1'b1}})) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seqsum_sink.sv
// tb/tb_seqsum_sink.sv - directed scoreboard bench for seqsum_sink

module tb_seqsum_sink;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [31:0]      y;
    logic             y_vld;
    logic             y_rdy;
    logic [31:0]      lim;
    logic             clr;
    logic [31:0]      out_data;
    logic [31:0]      out_dlt;
    logic             out_vld;
    logic             out_rdy;
    logic             over;
    logic [CNT_W-1:0] cnt;

    int total = 0;
    int bad   = 0;

    logic [63:0]      q[$];
    logic [31:0]      m_prev;
    logic             m_first;
    logic             m_over;
    logic [CNT_W-1:0] m_cnt;

    always #5 clk = ~clk;

    seqsum_sink #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .y        (y),
        .y_vld    (y_vld),
        .y_rdy    (y_rdy),
        .lim      (lim),
        .clr      (clr),
        .out_data (out_data),
        .out_dlt  (out_dlt),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .over     (over),
        .cnt      (cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset(input int n);
        rst   = 1'b1;
        y_vld = 1'b1;
        y     = 32'hDEAD_BEEF;
        clr   = 1'b0;
        out_rdy = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        rst     = 1'b0;
        y_vld   = 1'b0;
        q.delete();
        m_prev  = '0;
        m_first = 1'b1;
        m_over  = 1'b0;
        m_cnt   = '0;
    endtask

    // One clock: drive inputs, check registered outputs against the model,
    // then advance the model as the DUT should on the coming edge.
    task automatic cyc(input logic v, input logic [31:0] yy, input logic ordy, input logic c);
        logic        exp_rdy;
        logic        do_push;
        logic [31:0] d;
        logic [63:0] head;
        y_vld   = v;
        y       = yy;
        out_rdy = ordy;
        clr     = c;
        exp_rdy = (q.size() < DEPTH);
        chk("y_rdy", 32'(y_rdy), 32'(exp_rdy));
        chk("out_vld", 32'(out_vld), 32'(q.size() != 0));
        chk("over", 32'(over), 32'(m_over));
        chk("cnt", 32'(cnt), 32'(m_cnt));
        if (q.size() != 0) begin
            head = q[0];
            chk("out_data", out_data, head[63:32]);
            chk("out_dlt", out_dlt, head[31:0]);
            if (ordy) void'(q.pop_front());
        end
        do_push = v && exp_rdy;
        if (c) begin
            m_first = 1'b1;
            m_over  = 1'b0;
            m_cnt   = '0;
        end
        if (do_push) begin
            d = m_first ? yy : yy - m_prev;
            q.push_back({yy, d});
            m_prev  = yy;
            m_first = 1'b0;
            if (yy > lim) m_over = 1'b1;
            if (m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        lim = 32'd1000;
        do_reset(3);
        cyc(0, 0, 0, 0);

        // single word, one-cycle first-word latency
        cyc(1, 11, 1, 0);
        chk("first_data", out_data, 32'd11);
        chk("first_dlt", out_dlt, 32'd11);
        chk("first_cnt", 32'(cnt), 32'd1);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);

        // fill to full with downstream stalled, fifth word held, then drain
        cyc(0, 0, 0, 1);
        for (int i = 1; i <= 5; i++) cyc(1, i, 0, 0);
        chk("full_rdy", 32'(y_rdy), 32'd0);
        cyc(1, 5, 1, 0);
        cyc(1, 5, 1, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0);

        // threshold is strict
        lim = 32'd100;
        cyc(0, 0, 1, 1);
        cyc(1, 100, 1, 0);
        cyc(0, 0, 1, 0);
        chk("over_eq", 32'(over), 32'd0);
        cyc(1, 101, 1, 0);
        cyc(0, 0, 1, 0);
        chk("over_gt", 32'(over), 32'd1);
        cyc(0, 0, 1, 1);
        cyc(0, 0, 1, 0);
        chk("clr_over", 32'(over), 32'd0);
        chk("clr_cnt", 32'(cnt), 32'd0);

        // clr coincident with push
        cyc(1, 200, 1, 0);
        cyc(1, 210, 1, 1);
        cyc(1, 50, 1, 1);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);

        // delta wrap-around
        cyc(0, 0, 0, 1);
        cyc(1, 5, 0, 0);
        cyc(1, 3, 0, 0);
        cyc(0, 0, 1, 0);
        chk("wrap_dlt", out_dlt, 32'hFFFF_FFFE);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);

        // full with simultaneous push attempt and pop
        for (int i = 20; i < 24; i++) cyc(1, i, 0, 0);
        cyc(1, 24, 1, 0);
        cyc(1, 24, 1, 0);
        cyc(0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0);

        // counter saturation
        cyc(0, 0, 1, 1);
        for (int i = 0; i < 17; i++) cyc(1, 30 + i, 1, 0);
        cyc(0, 0, 1, 0);
        chk("cnt_sat", 32'(cnt), 32'd15);

        // reset mid-burst discards stored entries
        cyc(1, 7, 0, 0);
        cyc(1, 8, 0, 0);
        do_reset(1);
        chk("rst_vld", 32'(out_vld), 32'd0);
        chk("rst_cnt", 32'(cnt), 32'd0);
        cyc(0, 0, 1, 0);

        // random traffic
        lim = 32'h8000_0000;
        for (int i = 0; i < 60; i++) begin
            cyc(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
        end
        for (int i = 0; i < 6; i++) cyc(0, 0, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
